truth_table_sweeper: RTL
========================

# truth_table_sweeper

- Self-checking stimulus/capture stage wrapped around the 3-input Boolean function block.
- Drives A, B, C through all eight input combinations in ascending order and waits a programmable settle time per vector.
- Samples the function output F into an 8-bit truth-table register and compares it with an expected table.
- Reports done/pass, the number of mismatches and the first failing index; the truth table and pass flag go to board LEDs.

## Interface
- SETTLE_CYCLES, 4, cycles each vector is held before F is sampled; legal range 1..255.
- EXPECTED, 8'h97, expected truth table, bit i = F for {A,B,C} = i (A is MSB); 8'h97 encodes A'B' + B'C' + A'C' + ABC.
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  level input; a rising edge requests a sweep.
- f_in  input  1  F output of the function block under test.
- a_out  output  1  A drive to the function block.
- b_out  output  1  B drive to the function block.
- c_out  output  1  C drive to the function block.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start.
- pass  output  1  done && mismatch_count == 0.
- truth_table  output  8  captured F values; bit i = F at index i.
- mismatch_count  output  4  number of indices where truth_table differs from EXPECTED (0..8).
- first_fail_idx  output  3  lowest mismatching index; 0 when there is no mismatch.

## Operation
- **Start edge detection:** start_q registers start; an edge is start && !start_q. start_q resets to 1, so a start held high through reset does not trigger a sweep.
- **States:** IDLE, SETTLE, SAMPLE, DONE.
- **IDLE → SETTLE**, on a start edge:
  - idx = 0 and {a_out, b_out, c_out} = 3'b000.
  - settle_cnt = SETTLE_CYCLES - 1.
  - truth_table, mismatch_count and first_fail_idx are cleared; busy = 1, done = 0.
- **SETTLE:** settle_cnt decrements each cycle; when settle_cnt == 0, go to SAMPLE on the next edge.
- **SAMPLE** (one cycle):
  - truth_table[idx] <= f_in.
  - If f_in != EXPECTED[idx], mismatch_count increments. If this is the first mismatch of the sweep, first_fail_idx <= idx.
  - If idx == 7: go to DONE, busy = 0, done = 1.
  - Otherwise: idx increments, {a_out, b_out, c_out} follows idx, settle_cnt reloads to SETTLE_CYCLES - 1, and the state returns to SETTLE.
- **DONE:** all results and the A/B/C drive hold (drive stays 3'b111). A start edge behaves exactly like IDLE → SETTLE (results cleared, new sweep).
- **Start edges while busy** are ignored; no queuing.
- **{a_out, b_out, c_out}** always equals idx and never changes during SETTLE, so F is stable at sampling.
- **Counter widths:** mismatch_count is 4 bits and saturates naturally at its maximum of 8. settle_cnt is 8 bits.

## Timing
- **Reset values:** state = IDLE; a_out, b_out, c_out, busy, done, pass, truth_table, mismatch_count and first_fail_idx are all 0; idx = 0; start_q = 1.
- **Reset mid-sweep:** the sweep aborts immediately (asynchronously) and all outputs return to reset values; no partial results are retained.
- **Per-vector time:** SETTLE_CYCLES + 1 cycles; the SAMPLE edge for index i occurs (i+1)·(SETTLE_CYCLES+1) cycles after the start-accept edge.
- **Sweep latency:** done rises 8·(SETTLE_CYCLES+1) cycles after the accepting edge, which is 40 cycles at the default.
- **Output timing:** all outputs are registered. pass and done change on the same edge.
- **Minimum start timing:** start must be low for at least one cycle between requests for a new edge to register.

## Test plan
- **Correct function block:**
  - Stimulus: default parameters, start pulse.
  - Required response: done after 40 cycles; truth_table = 8'h97, mismatch_count = 0, pass = 1, first_fail_idx = 0, {a,b,c} = 3'b111.
- **Faulty model** (bench forces f_in = 0 when index = 7):
  - Required response: truth_table = 8'h17, mismatch_count = 1, first_fail_idx = 7, pass = 0.
- **Constant f_in = 1, with SETTLE_CYCLES = 1:**
  - Required response: done after 16 cycles; truth_table = 8'hFF, mismatch_count = 3, first_fail_idx = 3.
- **Start held high across reset release:**
  - Required response: no sweep (busy stays 0).
  - Then drop start and raise it again: sweep runs to done.
- **Second start edge during the sweep at cycle 10:**
  - Required response: ignored; done still at cycle 40.
  - A start edge while in DONE clears the results and restarts, with busy = 1 on the next cycle.
- **rst_n low at cycle 20 of a sweep:**
  - Required response: all outputs go to 0 immediately; a fresh start then produces a correct, complete result.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Sweeps A/B/C through all eight input combinations, captures F into a truth table
// and scores it against an expected table (mismatch count, first failing index, pass).
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  EXPECTED      = 8'h97
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       f_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] truth_table,
  output logic [3:0] mismatch_count,
  output logic [2:0] first_fail_idx
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned MM_W  = 4;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(7);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state,      w_state_nxt;
  logic             r_start_q;
  logic [IDX_W-1:0] r_idx,        w_idx_nxt;
  logic [CNT_W-1:0] r_settle_cnt, w_settle_cnt_nxt;
  logic [7:0]       r_tt,         w_tt_nxt;
  logic [MM_W-1:0]  r_mm,         w_mm_nxt;
  logic [IDX_W-1:0] r_ffi,        w_ffi_nxt;
  logic             r_busy,       w_busy_nxt;
  logic             r_done,       w_done_nxt;
  logic             r_pass,       w_pass_nxt;
  logic             w_start_edge;

  assign w_start_edge = start & ~r_start_q;

  // start_q resets high so a start held through reset release is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_start_q    <= 1'b1;
      r_idx        <= '0;
      r_settle_cnt <= '0;
      r_tt         <= '0;
      r_mm         <= '0;
      r_ffi        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_start_q    <= start;
      r_idx        <= w_idx_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_tt         <= w_tt_nxt;
      r_mm         <= w_mm_nxt;
      r_ffi        <= w_ffi_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_pass       <= w_pass_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_settle_cnt_nxt = r_settle_cnt;
    w_tt_nxt         = r_tt;
    w_mm_nxt         = r_mm;
    w_ffi_nxt        = r_ffi;
    w_busy_nxt       = r_busy;
    w_done_nxt       = r_done;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_edge) begin
          w_state_nxt      = S_SETTLE;
          w_idx_nxt        = '0;
          w_settle_cnt_nxt = SETTLE_LOAD;
          w_tt_nxt         = '0;
          w_mm_nxt         = '0;
          w_ffi_nxt        = '0;
          w_busy_nxt       = 1'b1;
          w_done_nxt       = 1'b0;
        end
      end
      S_SETTLE: begin
        if (r_settle_cnt == '0) begin
          w_state_nxt = S_SAMPLE;
        end else begin
          w_settle_cnt_nxt = r_settle_cnt - CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        w_tt_nxt[r_idx] = f_in;
        if (f_in != EXPECTED[r_idx]) begin
          w_mm_nxt = r_mm + MM_W'(1);
          if (r_mm == '0) w_ffi_nxt = r_idx;
        end
        if (r_idx == LAST_IDX) begin
          w_state_nxt = S_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_idx_nxt        = r_idx + IDX_W'(1);
          w_settle_cnt_nxt = SETTLE_LOAD;
          w_state_nxt      = S_SETTLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_pass_nxt = w_done_nxt && (w_mm_nxt == '0);
  end

  assign a_out          = r_idx[2];
  assign b_out          = r_idx[1];
  assign c_out          = r_idx[0];
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign truth_table    = r_tt;
  assign mismatch_count = r_mm;
  assign first_fail_idx = r_ffi;

endmodule
